mux_scan_reg: RTL and testbench

Parametrised, registered N:1 data multiplexer, the next generation of the team's 8-channel byte mux. It adds an output register with a valid strobe, an enable, and an auto-scan mode that round-robins through all channels with a programmable dwell time. It sits between a bank of parallel data sources and a single downstream consumer (display/logging path). Every output is registered and reports the index of the channel it carries.

---
 rtl/mux_scan_reg.sv | 114 +++++++++++
 tb/tb_mux_scan_reg.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_reg.sv
// Registered N:1 data multiplexer with manual select and auto-scan.
// Every output is registered; cur_sel always names the channel carried in y.
// In scan mode each channel is shown for DWELL enabled cycles, then the
// pointer advances round-robin, pulsing wrap when it returns to channel 0.
module mux_scan_reg #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned SEL_W    = $clog2(CHANNELS),
    parameter int unsigned DWELL    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data [CHANNELS],
    input  logic [SEL_W-1:0] sel,
    input  logic             mode,
    input  logic             en,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic [SEL_W-1:0] cur_sel,
    output logic             wrap
);

    localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SEL_W:0]   NumCh   = (SEL_W + 1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LastCh  = SEL_W'(CHANNELS - 1);
    localparam logic [CntW-1:0]  LastCnt = CntW'(DWELL - 1);

    typedef enum logic [1:0] {
        StIdle,
        StManual,
        StScan
    } state_e;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [CntW-1:0]  cnt_eff;
    logic [WIDTH-1:0] y_q, y_d;
    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
    logic             y_valid_q, y_valid_d;
    logic             wrap_q, wrap_d;

    // Next-state: mode is only acted on while en=1; en=0 holds everything
    // and drops the strobes.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        y_d       = y_q;
        cur_sel_d = cur_sel_q;
        y_valid_d = 1'b0;
        wrap_d    = 1'b0;
        cnt_eff   = '0;

        if (en) begin
            if (mode) begin
                state_d   = StScan;
                // Entering scan from any other state starts a full dwell.
                cnt_eff   = (state_q == StScan) ? cnt_q : '0;
                y_d       = data[ptr_q];
                cur_sel_d = ptr_q;
                y_valid_d = 1'b1;
                if (cnt_eff == LastCnt) begin
                    cnt_d = '0;
                    if (ptr_q == LastCh) begin
                        ptr_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + SEL_W'(1);
                    end
                end else begin
                    cnt_d = cnt_eff + CntW'(1);
                end
            end else begin
                state_d = StManual;
                cnt_d   = '0;
                // Out-of-range selects leave y/cur_sel/ptr untouched.
                if ({1'b0, sel} < NumCh) begin
                    y_d       = data[sel];
                    cur_sel_d = sel;
                    ptr_d     = sel;
                    y_valid_d = 1'b1;
                end
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            cnt_q     <= '0;
            y_q       <= '0;
            cur_sel_q <= '0;
            y_valid_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            y_q       <= y_d;
            cur_sel_q <= cur_sel_d;
            y_valid_q <= y_valid_d;
            wrap_q    <= wrap_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign cur_sel = cur_sel_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_mux_scan_reg.sv
// Directed bench for mux_scan_reg: default 8-channel/DWELL=4 instance plus a
// 5-channel, 16-bit, DWELL=1 corner instance.
module tb_mux_scan_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance
    logic        reset;
    logic [7:0]  d8 [8];
    logic [2:0]  sel;
    logic        mode;
    logic        en;
    logic [7:0]  y;
    logic        y_valid;
    logic [2:0]  cur_sel;
    logic        wrap;

    // Corner instance
    logic        reset2;
    logic [15:0] d16 [5];
    logic [2:0]  sel2;
    logic        mode2;
    logic        en2;
    logic [15:0] y2;
    logic        y_valid2;
    logic [2:0]  cur_sel2;
    logic        wrap2;

    int total = 0;
    int bad   = 0;

    logic [7:0]  exp_b [8];
    logic [15:0] exp_w [5];

    mux_scan_reg #(
        .WIDTH(8), .CHANNELS(8), .DWELL(4)
    ) u_dut (
        .clk(clk), .reset(reset), .data(d8), .sel(sel), .mode(mode), .en(en),
        .y(y), .y_valid(y_valid), .cur_sel(cur_sel), .wrap(wrap)
    );

    mux_scan_reg #(
        .WIDTH(16), .CHANNELS(5), .DWELL(1)
    ) u_dut5 (
        .clk(clk), .reset(reset2), .data(d16), .sel(sel2), .mode(mode2), .en(en2),
        .y(y2), .y_valid(y_valid2), .cur_sel(cur_sel2), .wrap(wrap2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance one clock and sample 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] ey, input logic ev,
                        input logic [2:0] es, input logic ew);
        chk({tag, ".y"}, {24'd0, y}, {24'd0, ey});
        chk({tag, ".valid"}, {31'd0, y_valid}, {31'd0, ev});
        chk({tag, ".cur_sel"}, {29'd0, cur_sel}, {29'd0, es});
        chk({tag, ".wrap"}, {31'd0, wrap}, {31'd0, ew});
    endtask

    task automatic chk16(input string tag, input logic [15:0] ey, input logic ev,
                         input logic [2:0] es, input logic ew);
        chk({tag, ".y"}, {16'd0, y2}, {16'd0, ey});
        chk({tag, ".valid"}, {31'd0, y_valid2}, {31'd0, ev});
        chk({tag, ".cur_sel"}, {29'd0, cur_sel2}, {29'd0, es});
        chk({tag, ".wrap"}, {31'd0, wrap2}, {31'd0, ew});
    endtask

    initial begin
        exp_b = '{8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hB4, 8'hB5, 8'hB6, 8'hB7};
        exp_w = '{16'h1000, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
        d8  = '{8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hB4, 8'hB5, 8'hB6, 8'hB7};
        d16 = '{16'h1000, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
        reset = 1'b1; en = 1'b0; mode = 1'b0; sel = 3'd0;
        reset2 = 1'b1; en2 = 1'b0; mode2 = 1'b0; sel2 = 3'd0;

        // Reset values
        step();
        step();
        chk8("reset", 8'h00, 1'b0, 3'd0, 1'b0);
        chk16("reset5", 16'h0000, 1'b0, 3'd0, 1'b0);
        reset = 1'b0;
        reset2 = 1'b0;

        // Idle with en=0: nothing moves
        step();
        chk8("idle_hold", 8'h00, 1'b0, 3'd0, 1'b0);

        // Manual sweep sel=0..7
        en = 1'b1; mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            step();
            chk8($sformatf("sweep%0d", i), exp_b[i], 1'b1, 3'(i), 1'b0);
        end

        // Scan from reset: each channel 4 cycles, wrap on cycle 32
        reset = 1'b1;
        step();
        reset = 1'b0; mode = 1'b1; en = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            step();
            chk8($sformatf("scan%0d", c), exp_b[((c - 1) / 4) % 8], 1'b1,
                 3'(((c - 1) / 4) % 8), (c == 32) ? 1'b1 : 1'b0);
        end

        // Enable gating: two enabled A2 cycles, 3 gated, then two more, then A3
        step();
        chk8("gate_a", 8'hA2, 1'b1, 3'd2, 1'b0);
        step();
        chk8("gate_b", 8'hA2, 1'b1, 3'd2, 1'b0);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk8($sformatf("gated%0d", k), 8'hA2, 1'b0, 3'd2, 1'b0);
        end
        en = 1'b1;
        step();
        chk8("resume_c", 8'hA2, 1'b1, 3'd2, 1'b0);
        step();
        chk8("resume_d", 8'hA2, 1'b1, 3'd2, 1'b0);
        step();
        chk8("resume_a3", 8'hA3, 1'b1, 3'd3, 1'b0);

        // Manual sel=5 then scan: B5 for a full dwell, then B6
        mode = 1'b0; sel = 3'd5;
        step();
        chk8("man5", 8'hB5, 1'b1, 3'd5, 1'b0);
        mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk8($sformatf("sw_b5_%0d", k), 8'hB5, 1'b1, 3'd5, 1'b0);
        end
        step();
        chk8("sw_b6a", 8'hB6, 1'b1, 3'd6, 1'b0);
        step();
        chk8("sw_b6b", 8'hB6, 1'b1, 3'd6, 1'b0);
        // Mid-dwell back to manual takes effect immediately
        mode = 1'b0; sel = 3'd2;
        step();
        chk8("sw_man2", 8'hA2, 1'b1, 3'd2, 1'b0);

        // Reset while scanning at B4
        sel = 3'd4;
        step();
        mode = 1'b1;
        step();
        chk8("pre_rst", 8'hB4, 1'b1, 3'd4, 1'b0);
        reset = 1'b1;
        step();
        chk8("mid_rst", 8'h00, 1'b0, 3'd0, 1'b0);
        reset = 1'b0;
        step();
        chk8("post_rst", 8'h00, 1'b1, 3'd0, 1'b0);
        // Data change mid-dwell is tracked on the next enabled edge
        d8[0] = 8'h5A;
        step();
        chk8("data_track", 8'h5A, 1'b1, 3'd0, 1'b0);
        d8[0] = 8'h00;
        en = 1'b0;

        // Corner: 5 channels, DWELL=1, wrap every 5th enabled cycle
        en2 = 1'b1; mode2 = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            chk16($sformatf("c5scan%0d", c), exp_w[(c - 1) % 5], 1'b1,
                  3'((c - 1) % 5), (((c - 1) % 5) == 4) ? 1'b1 : 1'b0);
        end
        // Out-of-range manual select holds y
        mode2 = 1'b0; sel2 = 3'd6;
        step();
        chk16("c5_oor", 16'h4444, 1'b0, 3'd4, 1'b0);
        sel2 = 3'd3;
        step();
        chk16("c5_man3", 16'h3333, 1'b1, 3'd3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
